// File: rtl/caesar_msg_feeder_if.sv
// Bundles the key-config channel, plaintext channel, core-facing outputs
// and message status of the Caesar message feeder.
interface caesar_msg_feeder_if #(
    parameter int CNT_W = 16
);
    // key configuration channel
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_op;
    logic             cfg_d1;
    logic [4:0]       cfg_k1;
    logic             cfg_d3;
    logic [4:0]       cfg_k3;
    // plaintext channel
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    // downstream pacing
    logic             out_en;
    // core-facing outputs
    logic             flag_cipher_operation;
    logic             key1_shift_direction;
    logic [4:0]       key1_shift_number;
    logic             key3_shift_direction;
    logic [4:0]       key3_shift_number;
    logic [7:0]       plaintext_char;
    logic             flag_valid_plaintext_char;
    // message status
    logic             msg_busy;
    logic             msg_done;
    logic [CNT_W-1:0] char_count;
    logic             err_cfg;

    // feeder side
    modport slave (
        input  cfg_valid, cfg_op, cfg_d1, cfg_k1, cfg_d3, cfg_k3,
        input  in_valid, in_char, in_last, out_en,
        output cfg_ready, in_ready,
        output flag_cipher_operation, key1_shift_direction, key1_shift_number,
        output key3_shift_direction, key3_shift_number,
        output plaintext_char, flag_valid_plaintext_char,
        output msg_busy, msg_done, char_count, err_cfg
    );

    // source / bench side
    modport master (
        output cfg_valid, cfg_op, cfg_d1, cfg_k1, cfg_d3, cfg_k3,
        output in_valid, in_char, in_last, out_en,
        input  cfg_ready, in_ready,
        input  flag_cipher_operation, key1_shift_direction, key1_shift_number,
        input  key3_shift_direction, key3_shift_number,
        input  plaintext_char, flag_valid_plaintext_char,
        input  msg_busy, msg_done, char_count, err_cfg
    );
endinterface

// File: rtl/caesar_msg_feeder.sv
// Upstream stage of the Caesar core: validates and latches the key config,
// buffers framed plaintext in a small FIFO and feeds one char per enabled
// cycle while a message is streaming.
module caesar_msg_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    caesar_msg_feeder_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t           state;
    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop, cfg_bad;
    logic [8:0]       head;

    logic             op_q, d1_q, d3_q;
    logic [4:0]       k1_q, k3_q;
    logic [7:0]       pchar_q;
    logic             strobe_q, done_q, err_q;
    logic [CNT_W-1:0] cnt_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign push    = bus.in_valid && !full;
    assign pop     = (state == STREAM) && bus.out_en && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign cfg_bad = (bus.cfg_k1 > 5'd26) || (bus.cfg_k3 > 5'd26) || (bus.cfg_k1 == bus.cfg_k3);

    // FIFO storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.in_last, bus.in_char};
    end

    // FIFO pointers; push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Message FSM with registered key, char and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            d1_q     <= 1'b0;
            k1_q     <= '0;
            d3_q     <= 1'b0;
            k3_q     <= '0;
            pchar_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        if (cfg_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q  <= bus.cfg_op;
                            d1_q  <= bus.cfg_d1;
                            k1_q  <= bus.cfg_k1;
                            d3_q  <= bus.cfg_d3;
                            k3_q  <= bus.cfg_k3;
                            err_q <= 1'b0;
                            cnt_q <= '0;
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (pop) begin
                        pchar_q  <= head[7:0];
                        strobe_q <= 1'b1;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        if (head[8]) state <= DONE;
                    end
                end
                DONE: begin
                    // pulse lands in the cycle after the last char's strobe
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready                 = (state == IDLE);
    assign bus.in_ready                  = !full;
    assign bus.msg_busy                  = (state == STREAM);
    assign bus.flag_cipher_operation     = op_q;
    assign bus.key1_shift_direction      = d1_q;
    assign bus.key1_shift_number         = k1_q;
    assign bus.key3_shift_direction      = d3_q;
    assign bus.key3_shift_number         = k3_q;
    assign bus.plaintext_char            = pchar_q;
    assign bus.flag_valid_plaintext_char = strobe_q;
    assign bus.msg_done                  = done_q;
    assign bus.char_count                = cnt_q;
    assign bus.err_cfg                   = err_q;
endmodule

// File: tb/tb_caesar_msg_feeder.sv
// Directed bench for caesar_msg_feeder: config validation, streaming,
// FIFO full/backpressure, out_en pacing and mid-message reset.
module tb_caesar_msg_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ndone = 0;
    int   done_cyc = 0;
    int   p0;
    byte  rx[$];
    int   rxc[$];

    caesar_msg_feeder_if #(.CNT_W(16)) bus ();

    caesar_msg_feeder #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // advance one edge and log strobes / done pulses seen after it
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.flag_valid_plaintext_char) begin
            rx.push_back(bus.plaintext_char);
            rxc.push_back(cyc);
        end
        if (bus.msg_done) begin
            ndone++;
            done_cyc = cyc;
        end
    endtask

    task automatic do_cfg(input logic op, input logic d1, input logic [4:0] k1,
                          input logic d3, input logic [4:0] k3);
        bus.cfg_op = op; bus.cfg_d1 = d1; bus.cfg_k1 = k1;
        bus.cfg_d3 = d3; bus.cfg_k3 = k3; bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic push(input byte ch, input logic last);
        bus.in_valid = 1'b1; bus.in_char = ch; bus.in_last = last;
        step();
    endtask

    task automatic chk_rx(input string tag, input string s);
        chk({tag, ".len"}, rx.size(), s.len());
        for (int i = 0; i < s.len() && i < rx.size(); i++) chk(tag, rx[i], s[i]);
    endtask

    initial begin
        logic pat [5];
        byte  expc [5];
        pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        expc = '{8'h70, 8'h70, 8'h71, 8'h71, 8'h72};
        bus.cfg_valid = 0; bus.cfg_op = 0; bus.cfg_d1 = 0; bus.cfg_k1 = 0;
        bus.cfg_d3 = 0; bus.cfg_k3 = 0; bus.in_valid = 0; bus.in_char = 0;
        bus.in_last = 0; bus.out_en = 0;

        // reset state
        repeat (3) step();
        chk("rst.pchar",  bus.plaintext_char, 0);
        chk("rst.strobe", bus.flag_valid_plaintext_char, 0);
        chk("rst.busy",   bus.msg_busy, 0);
        chk("rst.done",   bus.msg_done, 0);
        chk("rst.count",  bus.char_count, 0);
        chk("rst.err",    bus.err_cfg, 0);
        chk("rst.k1",     bus.key1_shift_number, 0);
        chk("rst.d3",     bus.key3_shift_direction, 0);
        chk("rst.inrdy",  bus.in_ready, 1);
        rst_n = 1'b1;
        step();

        // basic message "Abc"
        bus.out_en = 1'b1;
        chk("t1.cfgrdy", bus.cfg_ready, 1);
        do_cfg(0, 0, 5'd3, 1, 5'd5);
        chk("t1.busy", bus.msg_busy, 1);
        chk("t1.k1",   bus.key1_shift_number, 3);
        chk("t1.k3",   bus.key3_shift_number, 5);
        chk("t1.d3",   bus.key3_shift_direction, 1);
        chk("t1.cfgrdy_s", bus.cfg_ready, 0);
        rx.delete(); rxc.delete();
        push("A", 0); p0 = cyc;
        push("b", 0);
        push("c", 1);
        bus.in_valid = 0;
        repeat (5) step();
        chk_rx("t1.rx", "Abc");
        chk("t1.c0", rxc[0], p0 + 1);
        chk("t1.c2", rxc[2], p0 + 3);
        chk("t1.donecyc", done_cyc, p0 + 4);
        chk("t1.ndone", ndone, 1);
        chk("t1.count", bus.char_count, 3);
        chk("t1.k1end", bus.key1_shift_number, 3);
        chk("t1.busyend", bus.msg_busy, 0);

        // equal keys rejected, then good config
        do_cfg(0, 0, 5'd7, 1, 5'd7);
        chk("t2.err",  bus.err_cfg, 1);
        chk("t2.busy", bus.msg_busy, 0);
        chk("t2.k1",   bus.key1_shift_number, 3);
        do_cfg(1, 1, 5'd1, 0, 5'd2);
        chk("t2.err2", bus.err_cfg, 0);
        chk("t2.busy2", bus.msg_busy, 1);
        chk("t2.op",   bus.flag_cipher_operation, 1);
        chk("t2.k1b",  bus.key1_shift_number, 1);
        chk("t2.cnt0", bus.char_count, 0);
        push("z", 1);
        bus.in_valid = 0;
        repeat (4) step();
        chk("t2.ndone", ndone, 2);
        chk("t2.count", bus.char_count, 1);

        // out-of-range keys rejected, latched keys untouched
        do_cfg(0, 0, 5'd27, 0, 5'd4);
        chk("t3.err", bus.err_cfg, 1);
        chk("t3.k1",  bus.key1_shift_number, 1);
        chk("t3.k3",  bus.key3_shift_number, 2);
        chk("t3.op",  bus.flag_cipher_operation, 1);
        do_cfg(0, 0, 5'd4, 0, 5'd31);
        chk("t3.err31", bus.err_cfg, 1);
        chk("t3.busy", bus.msg_busy, 0);

        // FIFO full with out_en low, then drain
        bus.out_en = 1'b0;
        do_cfg(0, 1, 5'd2, 0, 5'd9);
        chk("t4.busy", bus.msg_busy, 1);
        rx.delete(); rxc.delete();
        for (int i = 0; i < 8; i++) begin
            chk("t4.inrdy_fill", bus.in_ready, 1);
            push(8'h30 + 8'(i), 0);
        end
        chk("t4.full", bus.in_ready, 0);
        bus.in_char = "8"; bus.in_last = 1'b1;
        step();
        chk("t4.full2", bus.in_ready, 0);
        chk("t4.nostrobe", rx.size(), 0);
        bus.out_en = 1'b1;
        step();
        chk("t4.inrdy_pop", bus.in_ready, 1);
        step();
        bus.in_valid = 0;
        chk("t4.inrdy_pp", bus.in_ready, 1);
        repeat (9) step();
        chk_rx("t4.rx", "012345678");
        for (int i = 1; i < rxc.size(); i++) chk("t4.consec", rxc[i], rxc[0] + i);
        chk("t4.count", bus.char_count, 9);
        chk("t4.ndone", ndone, 3);

        // out_en pacing
        bus.out_en = 1'b0;
        do_cfg(0, 0, 5'd4, 0, 5'd0);
        push("p", 0); push("q", 0); push("r", 1);
        bus.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            bus.out_en = pat[i];
            step();
            chk("t5.strobe", bus.flag_valid_plaintext_char, 32'(pat[i]));
            chk("t5.pchar",  bus.plaintext_char, 32'(expc[i]));
        end
        bus.out_en = 1'b0;
        repeat (3) step();
        chk("t5.ndone", ndone, 4);
        chk("t5.count", bus.char_count, 3);

        // reset mid-message
        bus.out_en = 1'b1;
        do_cfg(0, 0, 5'd5, 1, 5'd6);
        rx.delete(); rxc.delete();
        push("a", 0); push("b", 0); push("c", 0);
        chk("t6.pre", rx.size(), 2);
        rst_n = 1'b0;
        bus.in_valid = 0;
        #2;
        chk("t6.pchar",  bus.plaintext_char, 0);
        chk("t6.strobe", bus.flag_valid_plaintext_char, 0);
        chk("t6.count",  bus.char_count, 0);
        chk("t6.busy",   bus.msg_busy, 0);
        chk("t6.k1",     bus.key1_shift_number, 0);
        chk("t6.inrdy",  bus.in_ready, 1);
        step(); step();
        chk("t6.nodone", ndone, 4);
        rst_n = 1'b1;
        step();
        rx.delete(); rxc.delete();
        do_cfg(0, 0, 5'd8, 0, 5'd9);
        chk("t6.cnt0", bus.char_count, 0);
        push("x", 0); push("y", 1);
        bus.in_valid = 0;
        repeat (5) step();
        chk_rx("t6.rx", "xy");
        chk("t6.count2", bus.char_count, 2);
        chk("t6.ndone", ndone, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
